// File: rtl/button_conditioner.sv
// Button conditioner: synchronises a raw push-button pin, debounces it with a
// cycle counter and turns the accepted level into single-cycle press, release,
// long-press and auto-repeat event pulses. All outputs are registered.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Polarity is corrected before the synchroniser so every later stage sees
  // 1 = button active and the synchroniser's reset value means "released".
  logic sync_in;
  logic sync_reg [2];
  logic s;

  assign sync_in = ACTIVE_LOW ? ~btn_in : btn_in;
  assign s       = sync_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First synchroniser flop samples the asynchronous pin.
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= sync_in;
        end
      end else begin : g_chain
        // Later synchroniser flops resolve metastability of the previous stage.
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [DEB_W-1:0]    deb_cnt_reg, deb_cnt_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [REP_W-1:0]    rep_cnt_reg, rep_cnt_next;
  logic                long_fired_reg, long_fired_next;
  logic                pressed_reg, pressed_next;
  logic                press_pulse_reg, press_pulse_next;
  logic                release_pulse_reg, release_pulse_next;
  logic                long_pulse_reg, long_pulse_next;
  logic                repeat_pulse_reg, repeat_pulse_next;

  // Next-state, counter and output decode. Pulses default low every cycle.
  // Hold/repeat timers advance only on cycles spent in HELD with the input
  // still active; a release bounce (including the edge that returns to HELD)
  // leaves them frozen.
  always_comb begin
    state_next         = state_reg;
    deb_cnt_next       = deb_cnt_reg;
    hold_cnt_next      = hold_cnt_reg;
    rep_cnt_next       = rep_cnt_reg;
    long_fired_next    = long_fired_reg;
    pressed_next       = pressed_reg;
    press_pulse_next   = 1'b0;
    release_pulse_next = 1'b0;
    long_pulse_next    = 1'b0;
    repeat_pulse_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (s) begin
          state_next   = DEB_PRESS;
          deb_cnt_next = '0;
        end
      end

      DEB_PRESS: begin
        if (!s) begin
          state_next = IDLE;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next       = HELD;
          pressed_next     = 1'b1;
          press_pulse_next = 1'b1;
          hold_cnt_next    = '0;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_W'(1);
        end
      end

      HELD: begin
        if (!s) begin
          state_next   = DEB_RELEASE;
          deb_cnt_next = '0;
        end else if (!long_fired_reg) begin
          if (hold_cnt_reg == HOLD_LAST) begin
            long_pulse_next = 1'b1;
            long_fired_next = 1'b1;
            rep_cnt_next    = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end else if (REPEAT_EN) begin
          if (rep_cnt_reg == REP_LAST) begin
            repeat_pulse_next = 1'b1;
            rep_cnt_next      = '0;
          end else begin
            rep_cnt_next = rep_cnt_reg + REP_W'(1);
          end
        end
      end

      DEB_RELEASE: begin
        if (s) begin
          state_next = HELD;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next         = IDLE;
          pressed_next       = 1'b0;
          release_pulse_next = 1'b1;
          long_fired_next    = 1'b0;
        end else begin
          deb_cnt_next = deb_cnt_reg + DEB_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any press silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      deb_cnt_reg       <= '0;
      hold_cnt_reg      <= '0;
      rep_cnt_reg       <= '0;
      long_fired_reg    <= 1'b0;
      pressed_reg       <= 1'b0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      long_pulse_reg    <= 1'b0;
      repeat_pulse_reg  <= 1'b0;
    end else begin
      state_reg         <= state_next;
      deb_cnt_reg       <= deb_cnt_next;
      hold_cnt_reg      <= hold_cnt_next;
      rep_cnt_reg       <= rep_cnt_next;
      long_fired_reg    <= long_fired_next;
      pressed_reg       <= pressed_next;
      press_pulse_reg   <= press_pulse_next;
      release_pulse_reg <= release_pulse_next;
      long_pulse_reg    <= long_pulse_next;
      repeat_pulse_reg  <= repeat_pulse_next;
    end
  end

  assign pressed       = pressed_reg;
  assign press_pulse   = press_pulse_reg;
  assign release_pulse = release_pulse_reg;
  assign long_pulse    = long_pulse_reg;
  assign repeat_pulse  = repeat_pulse_reg;

endmodule
